row_xor_update_pipe_init: RTL and testbench

//  Parametrised XOR-update row: NUM_WR banks, each 2**INDEX_WIDTH rows of NUM_MUL words.
//  Per-bank masked read-modify-write XOR with same-index hazard forwarding.

---
 rtl/row_xor_update_pipe_init.sv | 164 ++++++++++++++++
 tb/tb_row_xor_update_pipe_init.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_xor_update_pipe_init.sv
// Banked XOR-update row store: masked read-modify-write per bank with one-deep
// hazard forwarding, a shared delayed read lane, and a post-reset zero-fill FSM.
module row_xor_update_pipe_init #(
    parameter int NUM_MUL     = 4,
    parameter int NUM_WR      = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int KEY_WIDTH   = 32,
    parameter int RD_LAT      = 7
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_WR*NUM_MUL-1:0]             arbiter_result,
    input  logic [NUM_WR-1:0]                     write_reg_0_valid,
    input  logic [NUM_WR*INDEX_WIDTH-1:0]         write_reg_0_index,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  write_reg_11_xor,
    input  logic [INDEX_WIDTH-1:0]                rd_index,
    input  logic [KEY_WIDTH-1:0]                  rd_key,
    input  logic [1:0]                            rd_opt,
    output logic [KEY_WIDTH-1:0]                  rd_key_out,
    output logic [1:0]                            rd_opt_out,
    output logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  rd_out,
    output logic                                  init_done
);
    localparam int ROW_W = NUM_MUL * DATA_WIDTH;
    localparam int ALL_W = NUM_WR * ROW_W;
    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam int DLY   = RD_LAT - 1;
    localparam int PW    = 2 + KEY_WIDTH + ALL_W;
    localparam logic [INDEX_WIDTH:0] CNT_ONE = (INDEX_WIDTH + 1)'(1);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    function automatic logic [ROW_W-1:0] expand_mask(input logic [NUM_MUL-1:0] m);
        logic [ROW_W-1:0] e;
        for (int j = 0; j < NUM_MUL; j++) begin
            e[j*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{m[j]}};
        end
        return e;
    endfunction

    state_t                 state_r, state_s;
    logic [INDEX_WIDTH:0]   cnt_r, cnt_s;
    logic                   init_done_r;
    logic                   run_s, init_wr_s;
    logic [INDEX_WIDTH-1:0] r1_index_r;
    logic [KEY_WIDTH-1:0]   r1_key_r;
    logic [1:0]             r1_opt_r;
    logic [ALL_W-1:0]       rd_row_s;
    logic [PW-1:0]          dly_r [DLY];

    // Fill FSM next state: walk every row once, then run until reset.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r[INDEX_WIDTH]) begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = ST_INIT;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = '0;
            end
        endcase
    end

    // Fill FSM state, counter and done flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            init_done_r <= (state_s == ST_RUN);
        end
    end

    assign run_s     = (state_r == ST_RUN);
    assign init_wr_s = (state_r == ST_INIT) && !cnt_r[INDEX_WIDTH];
    assign init_done = init_done_r;

    for (genvar g = 0; g < NUM_WR; g++) begin : g_bank
        logic [ROW_W-1:0]       mem [DEPTH];
        logic                   w1_valid_r, w2_valid_r;
        logic [INDEX_WIDTH-1:0] w1_index_r, w2_index_r;
        logic [NUM_MUL-1:0]     w1_mask_r;
        logic [ROW_W-1:0]       w1_xor_r, w1_old_r, w2_data_r, r1_row_r;
        logic [ROW_W-1:0]       w1_base_s, w1_new_s;

        // Write-lane valid bits; writes are only taken once the fill is over.
        always_ff @(posedge clk) begin
            if (!reset) begin
                w1_valid_r <= 1'b0;
                w2_valid_r <= 1'b0;
            end else begin
                w1_valid_r <= run_s & write_reg_0_valid[g];
                w2_valid_r <= w1_valid_r;
            end
        end

        // Array port plus write/read data stages; w2 holds the row committed last edge.
        always_ff @(posedge clk) begin
            if (init_wr_s) begin
                mem[cnt_r[INDEX_WIDTH-1:0]] <= '0;
            end else if (w1_valid_r) begin
                mem[w1_index_r] <= w1_new_s;
            end
            w1_index_r <= write_reg_0_index[g*INDEX_WIDTH +: INDEX_WIDTH];
            w1_mask_r  <= arbiter_result[g*NUM_MUL +: NUM_MUL];
            w1_xor_r   <= write_reg_11_xor[g*ROW_W +: ROW_W];
            w1_old_r   <= mem[write_reg_0_index[g*INDEX_WIDTH +: INDEX_WIDTH]];
            r1_row_r   <= mem[rd_index];
            w2_index_r <= w1_index_r;
            w2_data_r  <= w1_new_s;
        end

        // The array read raced the previous commit, so take the committed value instead.
        assign w1_base_s = (w2_valid_r && (w2_index_r == w1_index_r)) ? w2_data_r : w1_old_r;
        assign w1_new_s  = w1_base_s ^ (w1_xor_r & expand_mask(w1_mask_r));
        assign rd_row_s[g*ROW_W +: ROW_W] =
            (w2_valid_r && (w2_index_r == r1_index_r)) ? w2_data_r : r1_row_r;
    end

    // Read lane first stage; ops arriving during the fill become bubbles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r1_opt_r <= 2'b00;
        end else begin
            r1_opt_r <= run_s ? rd_opt : 2'b00;
        end
        r1_index_r <= rd_index;
        r1_key_r   <= rd_key;
    end

    // Forwarded result plus plain delay stages up to the configured latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DLY; k++) begin
                dly_r[k] <= '0;
            end
        end else begin
            dly_r[0] <= {r1_opt_r, r1_key_r, rd_row_s};
            for (int k = 1; k < DLY; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
        end
    end

    assign rd_opt_out = dly_r[DLY-1][PW-1 -: 2];
    assign rd_key_out = dly_r[DLY-1][ALL_W +: KEY_WIDTH];
    assign rd_out     = dly_r[DLY-1][ALL_W-1:0];
endmodule

// File: tb/tb_row_xor_update_pipe_init.sv
// Directed bench: a default-parameter instance for fill, write, hazard and reset
// scenarios, plus two small instances (RD_LAT 2 and 9) for streaming reads.
module tb_row_xor_update_pipe_init;
    localparam int NM = 4, NW = 8, IW = 12, DW = 64, KW = 32, LAT = 7;
    localparam int ROWW = NM * DW, TOTW = NM * NW * DW, DEPTH = 2 ** IW;
    localparam int SNM = 2, SNW = 2, SIW = 4, SDW = 8, SKW = 8;
    localparam int STOT = SNM * SNW * SDW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NW*NM-1:0] arbiter_result = '0;
    logic [NW-1:0]    wr_valid = '0;
    logic [NW*IW-1:0] wr_index = '0;
    logic [TOTW-1:0]  wr_xor = '0;
    logic [IW-1:0]    rd_index = '0;
    logic [KW-1:0]    rd_key = '0;
    logic [1:0]       rd_opt = '0;
    logic [KW-1:0]    rd_key_out;
    logic [1:0]       rd_opt_out;
    logic [TOTW-1:0]  rd_out;
    logic             init_done;

    logic [SIW-1:0]   s_rd_index = '0;
    logic [SKW-1:0]   s_rd_key = '0;
    logic [1:0]       s_rd_opt = '0;
    logic [SKW-1:0]   s2_key_out, s9_key_out;
    logic [1:0]       s2_opt_out, s9_opt_out;
    logic [STOT-1:0]  s2_out, s9_out;
    logic             s2_done, s9_done;

    int errors = 0;
    int checks = 0;
    logic [TOTW-1:0] exp_row;

    always #5 clk = ~clk;

    row_xor_update_pipe_init dut (
        .clk(clk), .reset(reset), .arbiter_result(arbiter_result),
        .write_reg_0_valid(wr_valid), .write_reg_0_index(wr_index),
        .write_reg_11_xor(wr_xor), .rd_index(rd_index), .rd_key(rd_key),
        .rd_opt(rd_opt), .rd_key_out(rd_key_out), .rd_opt_out(rd_opt_out),
        .rd_out(rd_out), .init_done(init_done)
    );

    row_xor_update_pipe_init #(.NUM_MUL(SNM), .NUM_WR(SNW), .INDEX_WIDTH(SIW),
        .DATA_WIDTH(SDW), .KEY_WIDTH(SKW), .RD_LAT(2)) dut_lat2 (
        .clk(clk), .reset(reset), .arbiter_result('0), .write_reg_0_valid('0),
        .write_reg_0_index('0), .write_reg_11_xor('0), .rd_index(s_rd_index),
        .rd_key(s_rd_key), .rd_opt(s_rd_opt), .rd_key_out(s2_key_out),
        .rd_opt_out(s2_opt_out), .rd_out(s2_out), .init_done(s2_done)
    );

    row_xor_update_pipe_init #(.NUM_MUL(SNM), .NUM_WR(SNW), .INDEX_WIDTH(SIW),
        .DATA_WIDTH(SDW), .KEY_WIDTH(SKW), .RD_LAT(9)) dut_lat9 (
        .clk(clk), .reset(reset), .arbiter_result('0), .write_reg_0_valid('0),
        .write_reg_0_index('0), .write_reg_11_xor('0), .rd_index(s_rd_index),
        .rd_key(s_rd_key), .rd_opt(s_rd_opt), .rd_key_out(s9_key_out),
        .rd_opt_out(s9_opt_out), .rd_out(s9_out), .init_done(s9_done)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_wr();
        wr_valid       = '0;
        arbiter_result = '0;
        wr_xor         = '0;
        wr_index       = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if (rd_opt_out !== 2'b00 || rd_key_out !== '0 || rd_out !== '0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: opt=%0h key=%0h rd_out_any=%b init_done=%b, required all 0",
                     rd_opt_out, rd_key_out, |rd_out, init_done);
        end
    endtask

    task automatic test_zero_fill();
        reset = 1'b1;
        tick(DEPTH);
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL fill_early: init_done=%b after %0d cycles, required 0", init_done, DEPTH);
        end
        tick();
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL fill_done: init_done=%b after %0d cycles, required 1", init_done, DEPTH + 1);
        end
        checks++;
        if (s2_done !== 1'b1 || s9_done !== 1'b1) begin
            errors++;
            $display("FAIL fill_small: done=%b/%b, required 1/1", s2_done, s9_done);
        end
        rd_index = '0;
        rd_key = 32'h1111_0000;
        rd_opt = 2'd1;
        tick();
        rd_index = 12'hFFF;
        rd_key = 32'h2222_0FFF;
        rd_opt = 2'd3;
        tick();
        rd_opt = 2'd0;
        tick(LAT - 2);
        checks++;
        if (rd_opt_out !== 2'd1 || rd_key_out !== 32'h1111_0000 || rd_out !== '0) begin
            errors++;
            $display("FAIL fill_row0: opt=%0h key=%0h data_any=%b, required opt=1 key=11110000 data 0",
                     rd_opt_out, rd_key_out, |rd_out);
        end
        tick();
        checks++;
        if (rd_opt_out !== 2'd3 || rd_key_out !== 32'h2222_0FFF || rd_out !== '0) begin
            errors++;
            $display("FAIL fill_last_row: opt=%0h key=%0h data_any=%b, required opt=3 key=22220fff data 0",
                     rd_opt_out, rd_key_out, |rd_out);
        end
    endtask

    task automatic test_masked_write();
        wr_valid = 8'h03;
        wr_index[0 +: IW] = 12'd5;
        wr_index[IW +: IW] = 12'd5;
        arbiter_result[0 +: NM] = 4'b0101;
        arbiter_result[NM +: NM] = 4'b1111;
        wr_xor[0 +: ROWW] = {4{64'hA5}};
        wr_xor[ROWW +: ROWW] = {4{64'hFF}};
        wr_valid[1] = 1'b0;
        tick();
        clear_wr();
        tick(2);
        rd_index = 12'd5;
        rd_key = 32'hCAFE_0005;
        rd_opt = 2'd1;
        tick();
        rd_opt = 2'd0;
        tick(LAT - 1);
        exp_row = '0;
        exp_row[63:0] = 64'hA5;
        exp_row[191:128] = 64'hA5;
        checks++;
        if (rd_opt_out !== 2'd1 || rd_key_out !== 32'hCAFE_0005 || rd_out !== exp_row) begin
            errors++;
            $display("FAIL masked_write: opt=%0h key=%0h bank0=%h others_any=%b, required bank0=%h others 0",
                     rd_opt_out, rd_key_out, rd_out[ROWW-1:0], |rd_out[TOTW-1:ROWW], exp_row[ROWW-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 8'h08;
        wr_index[3*IW +: IW] = 12'd9;
        arbiter_result[3*NM +: NM] = 4'b1111;
        wr_xor[3*ROWW +: ROWW] = {4{64'hF0}};
        tick();
        wr_xor[3*ROWW +: ROWW] = {4{64'h0F}};
        tick();
        clear_wr();
        tick();
        rd_index = 12'd9;
        rd_key = 32'hB2B_0009;
        rd_opt = 2'd2;
        tick();
        rd_opt = 2'd0;
        tick(LAT - 1);
        exp_row = '0;
        exp_row[3*ROWW +: ROWW] = {4{64'hFF}};
        checks++;
        if (rd_opt_out !== 2'd2 || rd_out !== exp_row) begin
            errors++;
            $display("FAIL back_to_back: opt=%0h bank3=%h, required opt=2 bank3=%h",
                     rd_opt_out, rd_out[3*ROWW +: ROWW], exp_row[3*ROWW +: ROWW]);
        end
    endtask

    task automatic test_read_visibility();
        wr_valid = 8'h04;
        wr_index[2*IW +: IW] = 12'd7;
        arbiter_result[2*NM +: NM] = 4'b1111;
        wr_xor[2*ROWW +: ROWW] = {4{64'h1}};
        rd_index = 12'd7;
        rd_key = 32'h0000_AAAA;
        rd_opt = 2'd1;
        tick();
        clear_wr();
        rd_key = 32'h0000_BBBB;
        rd_opt = 2'd2;
        tick();
        rd_opt = 2'd0;
        tick(LAT - 3);
        checks++;
        if (rd_opt_out !== 2'd0) begin
            errors++;
            $display("FAIL vis_latency: opt=%0h one cycle early, required 0", rd_opt_out);
        end
        tick();
        checks++;
        if (rd_opt_out !== 2'd1 || rd_key_out !== 32'h0000_AAAA || rd_out !== '0) begin
            errors++;
            $display("FAIL vis_same_cycle: opt=%0h key=%0h bank2=%h, required opt=1 key=aaaa data 0",
                     rd_opt_out, rd_key_out, rd_out[2*ROWW +: ROWW]);
        end
        tick();
        exp_row = '0;
        exp_row[2*ROWW +: ROWW] = {4{64'h1}};
        checks++;
        if (rd_opt_out !== 2'd2 || rd_key_out !== 32'h0000_BBBB || rd_out !== exp_row) begin
            errors++;
            $display("FAIL vis_next_cycle: opt=%0h key=%0h bank2=%h, required opt=2 key=bbbb bank2=%h",
                     rd_opt_out, rd_key_out, rd_out[2*ROWW +: ROWW], exp_row[2*ROWW +: ROWW]);
        end
    endtask

    task automatic test_reset_midop();
        rd_index = 12'd5;  rd_key = 32'h51; rd_opt = 2'd1;
        tick();
        rd_index = 12'd9;  rd_key = 32'h52; rd_opt = 2'd2;
        tick();
        rd_index = 12'd7;  rd_key = 32'h53; rd_opt = 2'd3;
        tick();
        rd_opt = 2'd0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL midop_init_done: init_done=%b after reset, required 0", init_done);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_opt_out !== 2'd0) begin
                errors++;
                $display("FAIL midop_flush: cycle %0d opt=%0h, required 0", i, rd_opt_out);
            end
            tick();
        end
        for (int i = 0; i < DEPTH + 100 && init_done !== 1'b1; i++) begin
            tick();
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL midop_refill_timeout: init_done=%b, required 1", init_done);
        end
        rd_index = 12'd5;
        rd_key = 32'h60;
        rd_opt = 2'd1;
        tick();
        rd_opt = 2'd0;
        tick(LAT - 1);
        checks++;
        if (rd_opt_out !== 2'd1 || rd_out !== '0) begin
            errors++;
            $display("FAIL midop_refill: opt=%0h bank0=%h, required opt=1 data 0",
                     rd_opt_out, rd_out[ROWW-1:0]);
        end
    endtask

    task automatic test_throughput();
        logic [1:0]     opt_q [100];
        logic [SKW-1:0] key_q [100];
        int j;
        for (int i = 0; i < 100; i++) begin
            opt_q[i] = 2'($urandom_range(0, 3));
            key_q[i] = SKW'($urandom_range(0, 255));
        end
        for (int c = 0; c < 110; c++) begin
            if (c < 100) begin
                s_rd_opt = opt_q[c];
                s_rd_key = key_q[c];
                s_rd_index = SIW'(c);
            end else begin
                s_rd_opt = 2'd0;
            end
            tick();
            j = c + 1 - 2;
            if (j >= 0 && j < 100) begin
                checks++;
                if (s2_opt_out !== opt_q[j] || s2_key_out !== key_q[j] || s2_out !== '0) begin
                    errors++;
                    $display("FAIL stream_lat2: item %0d opt=%0h key=%0h data=%h, required opt=%0h key=%0h data 0",
                             j, s2_opt_out, s2_key_out, s2_out, opt_q[j], key_q[j]);
                end
            end
            j = c + 1 - 9;
            if (j >= 0 && j < 100) begin
                checks++;
                if (s9_opt_out !== opt_q[j] || s9_key_out !== key_q[j] || s9_out !== '0) begin
                    errors++;
                    $display("FAIL stream_lat9: item %0d opt=%0h key=%0h data=%h, required opt=%0h key=%0h data 0",
                             j, s9_opt_out, s9_key_out, s9_out, opt_q[j], key_q[j]);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_zero_fill();
        test_masked_write();
        test_back_to_back();
        test_read_visibility();
        test_reset_midop();
        test_throughput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
